// File: rtl/master_in_port.sv
// Receiving end of the serial slave-to-master link.
// Grants the link with a ready/valid handshake, deserialises a fixed-length
// LSB-first frame, and buffers completed words in a first-word-fall-through FIFO.
module master_in_port #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_enable,
  input  logic                  slave_valid,
  input  logic                  rx_data,
  output logic                  master_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  rx_busy,
  output logic                  rx_done,
  output logic [CNT_WIDTH-1:0]  fifo_count
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rx_done_q, rx_done_d;
  logic [DATA_WIDTH-1:0] word;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, rd_next;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic handshake, last_bit, push, pop;

  // A free FIFO slot is required before granting, which reserves the slot
  // for the whole frame; only pops can happen while a frame is in flight.
  assign master_ready = !reset && (state_q == IDLE) && rx_enable &&
                        (count_q < CNT_WIDTH'(FIFO_DEPTH));
  assign handshake    = master_ready && slave_valid;
  assign last_bit     = (state_q == SHIFT) && (bit_cnt_q == BW'(DATA_WIDTH - 1));
  assign push         = last_bit;
  assign pop          = data_valid && data_ready;
  assign rd_next      = rd_ptr_q + PW'(1);

  assign data_out   = dout_q;
  assign data_valid = (count_q != '0);
  assign rx_busy    = (state_q != IDLE);
  assign rx_done    = rx_done_q;
  assign fifo_count = count_q;

  // Receive FSM next state: ALIGN skips the cycle where the slave first drives bit 0.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_done_d       = 1'b0;
    word            = shift_q;
    word[bit_cnt_q] = rx_data;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = ALIGN;
          bit_cnt_d = '0;
        end
      end
      ALIGN: state_d = SHIFT;
      SHIFT: begin
        shift_d   = word;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (last_bit) begin
          state_d   = IDLE;
          rx_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO occupancy and registered head word; the head holds its value when empty.
  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    dout_d = dout_q;
    if (count_d != '0) begin
      if (count_q == '0) begin
        dout_d = word;
      end else if (pop) begin
        dout_d = (count_q == CNT_WIDTH'(1)) ? word : mem_q[rd_next];
      end
    end
  end

  // Control and head-word registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_done_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_done_q <= rx_done_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_next;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

endmodule

// File: tb/tb_master_in_port.sv
// Testbench for master_in_port: scoreboard of expected words pushed at each
// accepted handshake and compared as words are popped from the FIFO.
module tb_master_in_port;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_enable;
  logic          slave_valid;
  logic          rx_data;
  logic          master_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
  logic          rx_busy;
  logic          rx_done;
  logic [CW-1:0] fifo_count;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  master_in_port #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .rx_enable(rx_enable), .slave_valid(slave_valid),
    .rx_data(rx_data), .master_ready(master_ready), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .rx_busy(rx_busy),
    .rx_done(rx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Runs one frame from a negedge; returns at the negedge after the last-bit edge.
  task automatic do_frame(input logic [DW-1:0] w, input bit pop_last, input bit drop_en,
                          output logic done_o, output logic [DW-1:0] popped, output bit hs_ok);
    int n;
    n = 0;
    hs_ok = 1'b1;
    popped = '0;
    done_o = 1'b0;
    slave_valid = 1'b1;
    #1;
    while (!master_ready) begin
      if (n >= 50) begin
        hs_ok = 1'b0;
        slave_valid = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    exp_q.push_back(w);
    @(negedge clk);
    slave_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_data = w[i];
      if (drop_en && i == 2) rx_enable = 1'b0;
      if (pop_last && i == DW - 1) begin
        popped = data_out;
        data_ready = 1'b1;
      end
      @(negedge clk);
      data_ready = 1'b0;
    end
    done_o = rx_done;
  endtask

  // Pops the head word at a negedge and returns what was presented.
  task automatic pop_word(output logic [DW-1:0] d, output logic v);
    d = data_out;
    v = data_valid;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_enable = 1'b1; slave_valid = 1'b0; rx_data = 1'b0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({master_ready, rx_busy, rx_done, data_valid} !== 4'b0000 || fifo_count !== '0 || data_out !== '0) begin
      fails++;
      $display("FAIL reset_state: mr=%b busy=%b done=%b dv=%b cnt=%0d dout=%h, required all 0",
               master_ready, rx_busy, rx_done, data_valid, fifo_count, data_out);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (master_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b required 1", master_ready);
    end
  endtask

  task automatic test_single;
    logic d; logic [DW-1:0] pw, got; bit ok; logic v;
    do_frame(8'hA5, 0, 0, d, pw, ok);
    tests++;
    if (!ok || d !== 1'b1) begin
      fails++; $display("FAIL single_done: hs=%0d rx_done=%b required hs=1 rx_done=1", ok, d);
    end
    tests++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL single_word: dout=%h dv=%b cnt=%0d required A5 1 1", data_out, data_valid, fifo_count);
    end
    pop_word(got, v);
    void'(exp_q.pop_front());
    tests++;
    if (rx_done !== 1'b0 || data_valid !== 1'b0 || fifo_count !== 3'd0 || data_out !== 8'hA5) begin
      fails++; $display("FAIL single_pop: done=%b dv=%b cnt=%0d dout=%h required 0 0 0 A5", rx_done, data_valid, fifo_count, data_out);
    end
  endtask

  task automatic test_fill;
    logic d; logic [DW-1:0] pw, got, e; bit ok; logic v;
    for (int k = 1; k <= 4; k++) begin
      do_frame(DW'(k), 0, 0, d, pw, ok);
      tests++;
      if (!ok || d !== 1'b1) begin
        fails++; $display("FAIL fill_frame%0d: hs=%0d rx_done=%b required 1 1", k, ok, d);
      end
    end
    tests++;
    if (fifo_count !== 3'd4 || master_ready !== 1'b0) begin
      fails++; $display("FAIL fill_full: cnt=%0d mr=%b required 4 0", fifo_count, master_ready);
    end
    slave_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (master_ready !== 1'b0 || rx_busy !== 1'b0) begin
        fails++; $display("FAIL fill_blocked: mr=%b busy=%b required 0 0", master_ready, rx_busy);
      end
    end
    pop_word(got, v);
    e = exp_q.pop_front();
    tests++;
    if (got !== e || v !== 1'b1) begin
      fails++; $display("FAIL fill_pop1: got %h dv=%b required %h 1", got, v, e);
    end
    tests++;
    if (master_ready !== 1'b1) begin
      fails++; $display("FAIL fill_ready_after_pop: got %b required 1", master_ready);
    end
    do_frame(8'h05, 0, 0, d, pw, ok);
    tests++;
    if (!ok || d !== 1'b1 || fifo_count !== 3'd4) begin
      fails++; $display("FAIL fill_frame5: hs=%0d done=%b cnt=%0d required 1 1 4", ok, d, fifo_count);
    end
    for (int k = 0; k < 4; k++) begin
      pop_word(got, v);
      e = exp_q.pop_front();
      tests++;
      if (got !== e || v !== 1'b1) begin
        fails++; $display("FAIL fill_order%0d: got %h dv=%b required %h 1", k, got, v, e);
      end
    end
  endtask

  task automatic test_simul_pop_write;
    logic d; logic [DW-1:0] pw, got, e; bit ok; logic v;
    do_frame(8'h11, 0, 0, d, pw, ok);
    do_frame(8'h22, 0, 0, d, pw, ok);
    do_frame(8'h33, 1, 0, d, pw, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok || pw !== e || fifo_count !== 3'd2 || d !== 1'b1) begin
      fails++; $display("FAIL simul_count: popped %h cnt=%0d done=%b required %h 2 1", pw, fifo_count, d, e);
    end
    for (int k = 0; k < 2; k++) begin
      pop_word(got, v);
      e = exp_q.pop_front();
      tests++;
      if (got !== e || v !== 1'b1) begin
        fails++; $display("FAIL simul_order%0d: got %h required %h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic d; logic [DW-1:0] pw, got, e, w; bit ok; logic v; int n;
    do_frame(8'h77, 0, 0, d, pw, ok);
    w = 8'h3C;
    n = 0;
    slave_valid = 1'b1;
    #1;
    while (!master_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    slave_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_data = w[i];
      @(negedge clk);
    end
    tests++;
    if (rx_busy !== 1'b1) begin
      fails++; $display("FAIL midreset_busy_before: got %b required 1", rx_busy);
    end
    reset = 1'b1;
    #1;
    exp_q.delete();
    tests++;
    if (master_ready !== 1'b0 || rx_busy !== 1'b0 || data_valid !== 1'b0 || fifo_count !== '0 || data_out !== '0) begin
      fails++; $display("FAIL midreset_clear: mr=%b busy=%b dv=%b cnt=%0d dout=%h required 0 0 0 0 00",
                        master_ready, rx_busy, data_valid, fifo_count, data_out);
    end
    for (int k = 0; k < 8; k++) begin
      rx_data = ~rx_data;
      @(negedge clk);
      tests++;
      if (rx_done !== 1'b0) begin
        fails++; $display("FAIL midreset_no_done: got %b required 0", rx_done);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    do_frame(8'hC3, 0, 0, d, pw, ok);
    pop_word(got, v);
    e = exp_q.pop_front();
    tests++;
    if (!ok || d !== 1'b1 || got !== e || v !== 1'b1) begin
      fails++; $display("FAIL midreset_next: got %h dv=%b done=%b required %h 1 1", got, v, d, e);
    end
  endtask

  task automatic test_rx_enable;
    logic d; logic [DW-1:0] pw, got, e; bit ok; logic v;
    rx_enable = 1'b0;
    slave_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (master_ready !== 1'b0 || rx_busy !== 1'b0) begin
        fails++; $display("FAIL en_gate: mr=%b busy=%b required 0 0", master_ready, rx_busy);
      end
    end
    rx_enable = 1'b1;
    do_frame(8'h5A, 0, 1, d, pw, ok);
    tests++;
    if (!ok || d !== 1'b1 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL en_drop_frame: hs=%0d done=%b cnt=%0d required 1 1 1", ok, d, fifo_count);
    end
    slave_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (rx_busy !== 1'b0 || master_ready !== 1'b0) begin
        fails++; $display("FAIL en_no_new_hs: busy=%b mr=%b required 0 0", rx_busy, master_ready);
      end
    end
    slave_valid = 1'b0;
    pop_word(got, v);
    e = exp_q.pop_front();
    tests++;
    if (got !== e || v !== 1'b1) begin
      fails++; $display("FAIL en_word: got %h dv=%b required %h 1", got, v, e);
    end
    rx_enable = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic d1, d2; logic [DW-1:0] pw, got, e; bit ok1, ok2; logic v; logic mr;
    do_frame(8'hFF, 0, 0, d1, pw, ok1);
    mr = master_ready;
    do_frame(8'h00, 0, 0, d2, pw, ok2);
    tests++;
    if (mr !== 1'b1 || !ok1 || !ok2 || d1 !== 1'b1 || d2 !== 1'b1 || fifo_count !== 3'd2) begin
      fails++; $display("FAIL b2b_timing: mr_at_H+10=%b done=%b/%b cnt=%0d required 1 1/1 2", mr, d1, d2, fifo_count);
    end
    for (int k = 0; k < 2; k++) begin
      pop_word(got, v);
      e = exp_q.pop_front();
      tests++;
      if (got !== e || v !== 1'b1) begin
        fails++; $display("FAIL b2b_word%0d: got %h required %h", k, got, e);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_simul_pop_write();
    test_reset_mid();
    test_rx_enable();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
